// File: rtl/serial_ftc_adder.sv
// Bit-serial four-operand adder: one 4:2 compressor cell feeding one serial
// full adder. It processes one bit position per clock, LSB first, for W+2 cycles.
module serial_ftc_adder #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  input  logic [W-1:0]   d,
  output logic           busy,
  output logic           done,
  output logic [W+1:0]   sum
);

  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] LAST = CW'(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        st_q, st_d;
  logic [W+1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [W+1:0]  res_q, res_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cin_q, cin_d, cprev_q, cprev_d, fac_q, fac_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic s1, cout, s, cc, sbit;

  always_comb begin
    // Compressor cell on the current bit slice
    s1   = a_q[0] ^ b_q[0] ^ c_q[0];
    cout = (a_q[0] & b_q[0]) | (a_q[0] & c_q[0]) | (b_q[0] & c_q[0]);
    s    = s1 ^ d_q[0] ^ cin_q;
    cc   = (s1 & d_q[0]) | (s1 & cin_q) | (d_q[0] & cin_q);
    // C and Cout carry weight 2, so they join the next bit position
    sbit = s ^ cprev_q ^ fac_q;

    st_d    = st_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    cprev_d = cprev_q;
    fac_d   = fac_q;

    case (st_q)
      RUN: begin
        a_d     = {1'b0, a_q[W+1:1]};
        b_d     = {1'b0, b_q[W+1:1]};
        c_d     = {1'b0, c_q[W+1:1]};
        d_d     = {1'b0, d_q[W+1:1]};
        res_d   = {sbit, res_q[W+1:1]};
        fac_d   = (s & cprev_q) | (s & fac_q) | (cprev_q & fac_q);
        cprev_d = cc;
        cin_d   = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d = {sbit, res_q[W+1:1]};
          st_d  = DONE;
        end
      end
      default: begin
        st_d = IDLE;
        if (start) begin
          a_d     = {2'b00, a};
          b_d     = {2'b00, b};
          c_d     = {2'b00, c};
          d_d     = {2'b00, d};
          cin_d   = 1'b0;
          cprev_d = 1'b0;
          fac_d   = 1'b0;
          cnt_d   = '0;
          st_d    = RUN;
        end
      end
    endcase

    busy_d = (st_d == RUN);
    done_d = (st_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      cprev_q <= 1'b0;
      fac_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      cprev_q <= cprev_d;
      fac_q   <= fac_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;

endmodule

// File: tb/tb_serial_ftc_adder.sv
// Directed and random checks for serial_ftc_adder at W=8.
module tb_serial_ftc_adder;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] a, b, c, d;
  logic       busy, done;
  logic [9:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  serial_ftc_adder #(.W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .sum(sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE/DONE and wait for done; checks latency,
  // result, and that sum holds its old value while busy.
  task automatic run_op(input string tag, input logic [7:0] ia, ib, ic, id,
                        input logic [9:0] exp);
    int nbusy;
    int ncyc;
    logic [9:0] s0;
    logic held;
    s0 = sum;
    held = 1'b1;
    a = ia; b = ib; c = ic; d = id;
    start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0;
    ncyc = 0;
    while (!done && ncyc < 40) begin
      if (busy) nbusy++;
      if (sum !== s0) held = 1'b0;
      tick();
      ncyc++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_busy_cycles"}, nbusy, 10);
    chk({tag, "_busy_low_at_done"}, busy, 1'b0);
    chk({tag, "_sum_held"}, held, 1'b1);
    chk({tag, "_sum"}, sum, exp);
  endtask

  initial begin
    int ndone;
    int nbusy;
    logic [9:0] s0;
    logic held;
    logic [7:0] ra, rb, rc, rd;

    reset = 1'b1; start = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 10'h000);

    run_op("zero", 8'h00, 8'h00, 8'h00, 8'h00, 10'h000);
    tick();
    chk("done_one_cycle", done, 1'b0);
    run_op("all_ff", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h3FC);
    tick();
    run_op("small", 8'h01, 8'h02, 8'h03, 8'h04, 10'h00A);
    tick();
    run_op("msb", 8'h80, 8'h80, 8'h80, 8'h80, 10'h200);
    tick();

    // start during RUN must be ignored
    a = 8'h11; b = 8'h11; c = 8'h11; d = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    a = 8'hFF; b = 8'hFF; c = 8'hFF; d = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        chk("ign_sum", sum, 10'h044);
      end
      tick();
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_idle", busy, 1'b0);

    // reset in the middle of RUN
    a = 8'hAA; b = 8'hAA; c = 8'hAA; d = 8'hAA;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_sum", sum, 10'h000);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("mid_quiet", ndone, 0);
    run_op("after_rst", 8'h01, 8'h02, 8'h04, 8'h08, 10'h00F);
    tick();

    // back-to-back: start held during DONE
    run_op("b2b_first", 8'h10, 8'h10, 8'h10, 8'h10, 10'h040);
    a = 8'h33; b = 8'h33; c = 8'h33; d = 8'h33;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy_rise", busy, 1'b1);
    chk("b2b_done_low", done, 1'b0);
    nbusy = 0;
    held = 1'b1;
    while (!done && nbusy < 40) begin
      if (sum !== 10'h040) held = 1'b0;
      nbusy++;
      tick();
    end
    chk("b2b_latency", nbusy, 10);
    chk("b2b_held", held, 1'b1);
    chk("b2b_sum", sum, 10'h0CC);
    tick();

    // random operands against a plain sum
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 8'($urandom); rd = 8'($urandom);
      run_op("rand", ra, rb, rc, rd,
             10'(ra) + 10'(rb) + 10'(rc) + 10'(rd));
      if (i % 3 == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
